nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  W  operand A; sampled on the accepting edge only.
REQ-006 b  input  W  operand B; sampled on the accepting edge only.
REQ-007 cin  input  1  carry-in to nibble 0; sampled on the accepting edge only.
REQ-008 busy  output  1  high while an addition is in progress (state BUSY).
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  W  registered result A+B+cin, low W bits.
REQ-011 cout  output  1  registered carry out of the MSB nibble.
REQ-012 ovf  output  1  registered signed overflow: carry into bit W-1 XOR carry out of bit W-1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 In IDLE with start=1 at an edge (accepting edge), the block SHALL latch a, b and cin into internal registers, clear sum, cout and ovf to 0, load nibble index k=0, and enter BUSY.
REQ-015 In IDLE with start=0, all state and outputs SHALL hold.
REQ-016 In BUSY, each edge SHALL add nibble k of latched A, latched B and the carry register using one 4-bit full-adder chain, write the 4-bit result into sum[4k+3:4k], store the chain carry-out into the carry register, and increment k.
REQ-017 On the BUSY edge where k = NIBBLES-1, the block SHALL also write cout from the chain carry-out and ovf from the carry into bit 3 XOR carry out of bit 3 of that nibble, and enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency: accepting edge at T0 -> final result registered at edge T0+NIBBLES -> done high during cycle following T0+NIBBLES; no other timing is permitted.
REQ-020 start SHALL be ignored in BUSY and DONE; a start held high through DONE SHALL be accepted on the first edge in IDLE.
REQ-021 Changes to a, b, cin after the accepting edge SHALL NOT affect the result.
REQ-022 sum, cout, ovf SHALL hold their final values after done until the next accepting edge.
REQ-023 busy SHALL equal (state==BUSY), done SHALL equal (state==DONE); both decoded from state registers, no combinational path from inputs.
REQ-024 Arithmetic SHALL be modulo 2^W with carry into cout; all-ones + all-ones + 1 SHALL give sum=all-ones, cout=1.
REQ-025 k SHALL never exceed NIBBLES-1; no wrap within one operation.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state IDLE, k=0, carry register 0, latched operands 0, sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-028 After rst_n rises, the first edge SHALL behave as IDLE, accepting start if high.

Verification
REQ-029 NIBBLES=4, a=16'h1234, b=16'h4321, cin=0, start 1 cycle -> busy 4 cycles, done one cycle later, sum=16'h5555, cout=0, ovf=0.
REQ-030 a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0; nibble carries ripple across all 4 BUSY cycles.
REQ-031 a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; a=16'h8000, b=16'h8000 -> sum=0, cout=1, ovf=1.
REQ-032 Operands changed to random values and start pulsed every cycle during BUSY -> result equals sample at accepting edge; no second operation starts until IDLE.
REQ-033 rst_n pulsed low during second BUSY cycle -> all outputs 0 immediately, no done; next start with 16'h0001+16'h0001 -> sum=16'h0002 after normal latency.
REQ-034 start held high continuously -> back-to-back operations, one accept every NIBBLES+2 cycles, done pulse each; random regression vs. reference model for NIBBLES=2 and 8.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - request/result bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit adder that processes one 4-bit nibble per clock
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          ovf_q;
    logic [KW-1:0] k;

    logic          accept;
    logic          last;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    full;
    logic [3:0]    low3;
    logic          c3;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == BUSY) && (k == K_LAST);

    // One 4-bit chain per cycle; the 3-bit partial sum exposes the carry into bit 3 for ovf.
    always_comb begin
        a_nib = a_q[{k, 2'b00} +: 4];
        b_nib = b_q[{k, 2'b00} +: 4];
        full  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        low3  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
        c3    = low3[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = BUSY;
            BUSY:    if (k == K_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k       <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k       <= '0;
        end else if (state == BUSY) begin
            sum_q[{k, 2'b00} +: 4] <= full[3:0];
            carry_q                <= full[4];
            // k stays at its last value on the final nibble so it never wraps.
            if (last) begin
                cout_q <= full[4];
                ovf_q  <= c3 ^ full[4];
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign bus.busy = (state == BUSY);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and model-checked bench for nibble_serial_adder
module tb_nibble_serial_adder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_if #(.NIBBLES(2)) bus2 ();
    nibble_serial_adder_if #(.NIBBLES(8)) bus8 ();

    nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    nibble_serial_adder #(.NIBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    nibble_serial_adder #(.NIBBLES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic scramble,
                         input logic [15:0] es, input logic ec, input logic eo);
        int n;
        bus4.a = av; bus4.b = bv; bus4.cin = ci; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        chk({tag, "_clear"}, 64'({bus4.busy, bus4.sum, bus4.cout, bus4.ovf}), 64'({1'b1, 16'h0000, 2'b00}));
        n = 0;
        while (bus4.busy && n < 20) begin
            n++;
            if (scramble) begin
                bus4.a = 16'($urandom); bus4.b = 16'($urandom);
                bus4.cin = 1'($urandom); bus4.start = 1'b1;
            end
            @(negedge clk);
        end
        bus4.start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(4));
        chk({tag, "_done"}, 64'(bus4.done), 64'(1));
        chk({tag, "_result"}, 64'({bus4.sum, bus4.cout, bus4.ovf}), 64'({es, ec, eo}));
        @(negedge clk);
        chk({tag, "_after"}, 64'({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf}),
            64'({2'b00, es, ec, eo}));
    endtask

    initial begin
        logic [32:0] m8;
        logic [8:0]  m2;
        logic [31:0] ra8;
        logic [31:0] rb8;
        logic [7:0]  ra2;
        logic [7:0]  rb2;
        logic        rc;
        int          n;
        int          pulses;
        int          first;
        int          lastp;

        errors = 0; checks = 0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_op("basic",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        do_op("scramble",  16'h0F0F, 16'h00F1, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b0);

        // abort in the second BUSY cycle
        bus4.a = 16'h1111; bus4.b = 16'h1111; bus4.cin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        chk("abort_partial", 64'({bus4.busy, bus4.sum}), 64'({1'b1, 16'h0002}));
        #2 rst_n = 1'b0;
        #1 chk("abort_async", 64'({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus4.done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'(0));
        do_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // start held high: one accept every NIBBLES+2 cycles
        bus4.a = 16'h0101; bus4.b = 16'h0202; bus4.cin = 1'b0; bus4.start = 1'b1;
        pulses = 0; first = 0; lastp = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus4.done) begin
                pulses++;
                if (first == 0) first = i;
                lastp = i;
                chk("b2b_sum", 64'({bus4.sum, bus4.cout, bus4.ovf}), 64'({16'h0303, 2'b00}));
            end
        end
        bus4.start = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'(3));
        chk("b2b_first", 64'(first), 64'(5));
        chk("b2b_last", 64'(lastp), 64'(17));
        repeat (8) @(negedge clk);

        // NIBBLES=2 regression against an arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra2 = (i == 0) ? 8'hFF : 8'($urandom);
            rb2 = (i == 0) ? 8'hFF : 8'($urandom);
            rc  = (i == 0) ? 1'b1  : 1'($urandom);
            m2  = {1'b0, ra2} + {1'b0, rb2} + 9'(rc);
            bus2.a = ra2; bus2.b = rb2; bus2.cin = rc; bus2.start = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                bus2.start = 1'b0;
                n++;
            end while (!bus2.done && n < 30);
            chk("n2_latency", 64'(n), 64'(3));
            chk("n2_result", 64'({bus2.sum, bus2.cout, bus2.ovf}),
                64'({m2[7:0], m2[8], (ra2[7] == rb2[7]) && (m2[7] != ra2[7])}));
            @(negedge clk);
        end

        // NIBBLES=8 regression against an arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra8 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            rb8 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            rc  = (i == 0) ? 1'b1 : 1'($urandom);
            m8  = {1'b0, ra8} + {1'b0, rb8} + 33'(rc);
            bus8.a = ra8; bus8.b = rb8; bus8.cin = rc; bus8.start = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                bus8.start = 1'b0;
                n++;
            end while (!bus8.done && n < 30);
            chk("n8_latency", 64'(n), 64'(9));
            chk("n8_result", 64'({bus8.sum, bus8.cout, bus8.ovf}),
                64'({m8[31:0], m8[32], (ra8[31] == rb8[31]) && (m8[31] != ra8[31])}));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
